bc_guess_scorer: RTL and testbench
==================================

// Module: bc_guess_scorer
// PURPOSE
//  Sequenced scoring engine for the Bulls & Cows game controller. On a start pulse it
//  latches a 4-digit guess and a 4-digit secret. It walks all 16 digit pairs through one
//  shared nibble comparator, one pair per cycle, and reports bulls, cows, win, and guess
//  validity (digits 0-9, no repeats). The game FSM uses it in both phases: to validate
//  secrets during S1/S2, and to score tries during T1/T2.
// PARAMETERS
//  NUM_DIGITS  4   digits per code; pair count = NUM_DIGITS^2
//  DIGIT_W     4   bits per digit; digit 0 = code[3:0]
//  MAX_DIGIT   9   largest legal digit value
// PORTS
//  clock    in   1   system clock, rising edge
//  reset    in   1   synchronous, active-high
//  start    in   1   request; sampled only in IDLE
//  code     in   16  guess (or secret under validation), 4 nibbles
//  secret   in   16  opponent secret; don't-care in validate-only use
//  busy     out  1   high from the accepting edge until done falls
//  done     out  1   one-cycle pulse; results valid from this cycle on
//  bulls    out  3   digits equal at the same position, 0..4
//  cows     out  4   code[i]==secret[j] with i!=j, 0..12
//  win      out  1   bulls==NUM_DIGITS
//  valid    out  1   every code digit <=MAX_DIGIT and no two code digits equal
// BEHAVIOUR
//  Reset: state=IDLE. busy=done=win=0, bulls=cows=0, valid=0, i=j=0.
//  Interface: reset is reset, synchronous, active-high; clock is clock.
//  States: IDLE -> SCAN -> DONE -> IDLE.
//  IDLE
//   - If start is high at edge N: latch code and secret, clear accumulators,
//     set i=j=0, go to SCAN. busy=1 from edge N.
//   - start at any other time is ignored; no queueing.
//  SCAN, one pair (i outer, j inner) per cycle
//   - i==j and code[i]==secret[j]: bulls_acc += 1.
//   - i!=j and code[i]==secret[j]: cows_acc += 1.
//   - i<j and code[i]==code[j]: dup flag set.
//   - j==0: check code[i] > MAX_DIGIT; range flag set if true.
//   - j wraps 3->0 with i+1. The pair (3,3) is processed at edge N+16.
//  Transition to DONE, at edge N+16
//   - Output registers load final values, including the (3,3) increment.
//   - valid = !dup && !range. win = (final bulls==4).
//  DONE: done=1 for exactly one cycle, then IDLE with busy=0.
//  Result holding: outputs hold until the next accepting edge. At that edge they
//   are NOT cleared; they change only at the next N+16 edge.
//  Latency: done is high in the cycle after edge N+16. Minimum start-to-start spacing
//   is 18 edges (a start in the done cycle is ignored).
//  Inputs: code and secret may change freely after edge N; only latched copies are used.
//  Reset mid-SCAN or in DONE: immediate return to IDLE with reset values. No done pulse.
//  Simultaneous reset and start: reset wins; start is not accepted.
//  Widths: accumulators saturate never (max 4/12 fit). Counters i,j are 2-bit and wrap.
// STRUCTURE
//  bc_pkg holds:
//   - NUM_DIGITS, DIGIT_W, MAX_DIGIT
//   - typedef logic [3:0] digit_t
//   - typedef enum {IDLE, SCAN, DONE} scorer_state_t
//   - a function digit_at(code, idx)
//  No sub-module; a single comparator and the muxes stay inline.
// TESTING
//  1 secret=16'h1234, code=16'h1234, start -> done after edge N+16; bulls=4 cows=0 win=1 valid=1.
//  2 secret=16'h1234, code=16'h4321 -> bulls=0 cows=4 win=0 valid=1.
//  3 secret=16'h5678, code=16'h1123 -> bulls=0 cows=0 valid=0 (dup).
//    Same for code=16'h12A4 -> valid=0 (range).
//  4 start re-pulsed at edges N+3 and N+17 -> ignored. Exactly one done.
//    busy low only after the done cycle.
//  5 reset at edge N+8 -> busy=done=0 next cycle, bulls=cows=0, no done pulse.
//    A new start is then accepted normally.
//  6 code changed at N+1 to 16'h9999 -> results still reflect the latched code.
//    Back-to-back runs hold the previous results until N+16.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared definitions for the Bulls & Cows guess scorer.
//   NUM_DIGITS  digits per code (pair count is NUM_DIGITS^2)
//   DIGIT_W     bits per digit; digit 0 lives in code[DIGIT_W-1:0]
//   MAX_DIGIT   largest legal digit value
//   digit_t         one code digit
//   scorer_state_t  scorer FSM states
//   digit_at()      extracts digit idx from a packed code word
package bc_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGIT  = 9;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scorer_state_t;

   function automatic digit_t digit_at(input logic [NUM_DIGITS*DIGIT_W-1:0] code,
                                       input logic [1:0]                    idx);
      return code[DIGIT_W*int'(idx) +: DIGIT_W];
   endfunction

endpackage

// File: rtl/bc_guess_scorer.sv
// Sequenced Bulls & Cows scoring engine.
// On an accepted start the guess (code) and secret are latched, then all 16 digit
// pairs (i outer, j inner) are walked one per cycle through a shared digit
// comparator. The final pair loads the result registers and raises done for one
// cycle. Results hold until the last pair of the next run.
//
// Handshake: start is sampled only while idle; busy is high from the accepting
// edge until done falls; done is a one-cycle pulse and the result outputs are
// valid from that cycle until the final pair of the next run.
//
// Ports
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-high
//   start   in   request, sampled only in IDLE
//   code    in   [15:0] guess (or secret under validation)
//   secret  in   [15:0] opponent secret
//   busy    out  run in progress
//   done    out  one-cycle completion pulse
//   bulls   out  [2:0] same-position matches
//   cows    out  [3:0] cross-position matches
//   win     out  bulls == NUM_DIGITS
//   valid   out  all code digits legal and distinct
module bc_guess_scorer
   import bc_pkg::*;
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] code,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
   output logic                          busy,
   output logic                          done,
   output logic [2:0]                    bulls,
   output logic [3:0]                    cows,
   output logic                          win,
   output logic                          valid
);

   scorer_state_t                 state;
   logic [NUM_DIGITS*DIGIT_W-1:0] code_q;
   logic [NUM_DIGITS*DIGIT_W-1:0] secret_q;
   logic [1:0]                    i;
   logic [1:0]                    j;
   logic [2:0]                    bulls_acc;
   logic [3:0]                    cows_acc;
   logic                          dup_flag;
   logic                          range_flag;

   digit_t     code_i;
   digit_t     code_j;
   digit_t     secret_j;
   logic       match;
   logic [2:0] bulls_nxt;
   logic [3:0] cows_nxt;
   logic       dup_nxt;
   logic       range_nxt;
   logic       last_pair;

   // Next accumulator values for the pair (i,j) currently addressed. The final
   // pair's contribution is folded straight into the output registers.
   always_comb begin
      code_i    = digit_at(code_q, i);
      code_j    = digit_at(code_q, j);
      secret_j  = digit_at(secret_q, j);
      match     = (code_i == secret_j);
      bulls_nxt = bulls_acc;
      cows_nxt  = cows_acc;
      dup_nxt   = dup_flag;
      range_nxt = range_flag;
      if (match && (i == j)) bulls_nxt = bulls_acc + 3'd1;
      if (match && (i != j)) cows_nxt  = cows_acc + 4'd1;
      // Each unordered digit pair is checked for duplicates once (i<j).
      if ((i < j) && (code_i == code_j)) dup_nxt = 1'b1;
      // Range is checked once per code digit, on its first inner step.
      if ((j == 2'd0) && (code_i > digit_t'(MAX_DIGIT))) range_nxt = 1'b1;
      last_pair = (i == 2'd3) && (j == 2'd3);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         code_q     <= '0;
         secret_q   <= '0;
         i          <= 2'd0;
         j          <= 2'd0;
         bulls_acc  <= 3'd0;
         cows_acc   <= 4'd0;
         dup_flag   <= 1'b0;
         range_flag <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bulls      <= 3'd0;
         cows       <= 4'd0;
         win        <= 1'b0;
         valid      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  code_q     <= code;
                  secret_q   <= secret;
                  i          <= 2'd0;
                  j          <= 2'd0;
                  bulls_acc  <= 3'd0;
                  cows_acc   <= 4'd0;
                  dup_flag   <= 1'b0;
                  range_flag <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SCAN;
               end
            end
            SCAN: begin
               bulls_acc  <= bulls_nxt;
               cows_acc   <= cows_nxt;
               dup_flag   <= dup_nxt;
               range_flag <= range_nxt;
               j          <= j + 2'd1;
               if (j == 2'd3) i <= i + 2'd1;
               if (last_pair) begin
                  bulls <= bulls_nxt;
                  cows  <= cows_nxt;
                  win   <= (bulls_nxt == 3'(NUM_DIGITS));
                  valid <= !dup_nxt && !range_nxt;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bc_guess_scorer.sv
module tb_bc_guess_scorer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [15:0] code;
   logic [15:0] secret;
   logic        busy;
   logic        done;
   logic [2:0]  bulls;
   logic [3:0]  cows;
   logic        win;
   logic        valid;

   int checks_total;
   int checks_passed;

   // Results of the previous completed run; outputs must hold these until the
   // final pair of the next run.
   logic [2:0] prev_bulls;
   logic [3:0] prev_cows;
   logic       prev_win;
   logic       prev_valid;

   typedef struct {
      logic [15:0] code;
      logic [15:0] secret;
      logic [2:0]  bulls;
      logic [3:0]  cows;
      logic        win;
      logic        valid;
   } vec_t;

   vec_t vecs[$];

   bc_guess_scorer dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .code   (code),
      .secret (secret),
      .busy   (busy),
      .done   (done),
      .bulls  (bulls),
      .cows   (cows),
      .win    (win),
      .valid  (valid)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check_outputs(input string tag, input logic [2:0] b, input logic [3:0] c,
                                input logic w, input logic v);
      check({tag, " bulls"}, 16'(bulls), 16'(b));
      check({tag, " cows"},  16'(cows),  16'(c));
      check({tag, " win"},   16'(win),   16'(w));
      check({tag, " valid"}, 16'(valid), 16'(v));
   endtask

   // Drives one run from IDLE (called just after a falling edge) and checks
   // acceptance, result hold, latency, results and return to idle.
   task automatic run_vec(input string tag, input vec_t v, input bit scramble);
      int lat;
      bit hold_ok;
      code   = v.code;
      secret = v.secret;
      start  = 1'b1;
      cycle();                      // edge N
      start = 1'b0;
      check({tag, " accept busy/done"}, {busy, done}, 16'b10);
      if (scramble) begin
         code   = 16'h9999;
         secret = 16'h0000;
      end
      lat = 0;
      hold_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         cycle();                   // edge N+k
         if (done) begin
            lat = k;
            break;
         end
         if (!busy || bulls !== prev_bulls || cows !== prev_cows ||
             win !== prev_win || valid !== prev_valid)
            hold_ok = 1'b0;
      end
      check({tag, " latency"}, 16'(lat), 16'd16);
      check({tag, " hold/busy during scan"}, 16'(hold_ok), 16'd1);
      check({tag, " busy in done"}, 16'(busy), 16'd1);
      check_outputs(tag, v.bulls, v.cows, v.win, v.valid);
      cycle();
      check({tag, " idle busy/done"}, {busy, done}, 16'b00);
      prev_bulls = v.bulls;
      prev_cows  = v.cows;
      prev_win   = v.win;
      prev_valid = v.valid;
   endtask

   initial begin
      vec_t v;
      int   dones;
      int   done_edge;
      bit   busy16;
      bit   busy17;

      checks_total  = 0;
      checks_passed = 0;
      prev_bulls = 3'd0;
      prev_cows  = 4'd0;
      prev_win   = 1'b0;
      prev_valid = 1'b0;

      // digit 0 is the low nibble
      vecs.push_back('{16'h1234, 16'h1234, 3'd4, 4'd0,  1'b1, 1'b1});
      vecs.push_back('{16'h4321, 16'h1234, 3'd0, 4'd4,  1'b0, 1'b1});
      vecs.push_back('{16'h1123, 16'h5678, 3'd0, 4'd0,  1'b0, 1'b0});
      vecs.push_back('{16'h12A4, 16'h5678, 3'd0, 4'd0,  1'b0, 1'b0});
      vecs.push_back('{16'h1243, 16'h1234, 3'd2, 4'd2,  1'b0, 1'b1});
      vecs.push_back('{16'h1111, 16'h1111, 3'd4, 4'd12, 1'b1, 1'b0});
      vecs.push_back('{16'h9876, 16'h0123, 3'd0, 4'd0,  1'b0, 1'b1});
      vecs.push_back('{16'h1234, 16'h5555, 3'd0, 4'd0,  1'b0, 1'b1});
      vecs.push_back('{16'h5FFF, 16'hFFF5, 3'd2, 4'd8,  1'b0, 1'b0});
      vecs.push_back('{16'h0789, 16'h9870, 3'd0, 4'd4,  1'b0, 1'b1});

      reset  = 1'b1;
      start  = 1'b0;
      code   = 16'h0;
      secret = 16'h0;
      repeat (3) cycle();
      reset = 1'b0;
      check("reset busy/done", {busy, done}, 16'b00);
      check_outputs("reset", 3'd0, 4'd0, 1'b0, 1'b0);

      // table-driven runs, back to back so each also checks result hold
      foreach (vecs[n]) run_vec($sformatf("vec%0d", n), vecs[n], 1'b0);

      // inputs scrambled after acceptance: latched copies must be used
      v = '{16'h1234, 16'h1234, 3'd4, 4'd0, 1'b1, 1'b1};
      run_vec("latched", v, 1'b1);

      // start re-pulsed mid-scan (edge N+3) and in the done cycle (edge N+17)
      code   = 16'h4321;
      secret = 16'h1234;
      start  = 1'b1;
      cycle();
      start = 1'b0;
      dones = 0;
      done_edge = 0;
      busy16 = 1'b0;
      busy17 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         start = (k == 3 || k == 17);
         cycle();
         start = 1'b0;
         if (done) begin
            dones++;
            done_edge = k;
         end
         if (k == 16) busy16 = busy;
         if (k == 17) busy17 = busy;
      end
      check("restart done count", 16'(dones), 16'd1);
      check("restart done edge", 16'(done_edge), 16'd16);
      check("restart busy in done", 16'(busy16), 16'd1);
      check("restart busy after done", 16'(busy17), 16'd0);
      check("restart still idle", 16'(busy), 16'd0);
      prev_bulls = 3'd0;
      prev_cows  = 4'd4;
      prev_win   = 1'b0;
      prev_valid = 1'b1;
      check_outputs("restart", prev_bulls, prev_cows, prev_win, prev_valid);

      // reset at edge N+8 aborts the run with no done pulse
      code   = 16'h1234;
      secret = 16'h1234;
      start  = 1'b1;
      cycle();
      start = 1'b0;
      repeat (7) cycle();
      reset = 1'b1;
      cycle();                      // edge N+8
      reset = 1'b0;
      check("abort busy/done", {busy, done}, 16'b00);
      check_outputs("abort", 3'd0, 4'd0, 1'b0, 1'b0);
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         cycle();
         if (done || busy) dones++;
      end
      check("abort no activity", 16'(dones), 16'd0);
      prev_bulls = 3'd0;
      prev_cows  = 4'd0;
      prev_win   = 1'b0;
      prev_valid = 1'b0;
      v = '{16'h3210, 16'h0123, 3'd0, 4'd4, 1'b0, 1'b1};
      run_vec("after abort", v, 1'b0);

      // reset and start together: reset wins
      code   = 16'h1234;
      secret = 16'h1234;
      reset  = 1'b1;
      start  = 1'b1;
      cycle();
      reset = 1'b0;
      start = 1'b0;
      check("reset+start busy", 16'(busy), 16'd0);
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (done || busy) dones++;
      end
      check("reset+start no run", 16'(dones), 16'd0);
      prev_bulls = 3'd0;
      prev_cows  = 4'd0;
      prev_win   = 1'b0;
      prev_valid = 1'b0;
      v = '{16'h1234, 16'h1234, 3'd4, 4'd0, 1'b1, 1'b1};
      run_vec("after reset+start", v, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
